// File: rtl/lap_controller_if.sv
// Handshake bundle between the stopwatch lap controller and its surroundings:
// button pulses, tick and live time in; counter enable, clear and display out.
interface lap_controller_if;
    logic        start_stop;
    logic        lap_reset;
    logic        tick;
    logic [15:0] time_in;
    logic        count;
    logic        clr;
    logic [15:0] disp;
    logic        frozen;
    logic [3:0]  lap_cnt;
    logic        ovf;

    modport master (
        output start_stop, lap_reset, tick, time_in,
        input  count, clr, disp, frozen, lap_cnt, ovf
    );

    modport slave (
        input  start_stop, lap_reset, tick, time_in,
        output count, clr, disp, frozen, lap_cnt, ovf
    );
endinterface

// File: rtl/lap_controller.sv
// Stopwatch lap controller: run/stop/split FSM with a timed split freeze,
// BCD lap counter and overflow halt at MAX_TIME.
module lap_controller #(
    parameter int          HOLD_TICKS = 30,
    parameter logic [15:0] MAX_TIME   = 16'h9599
) (
    input logic             clk,
    input logic             reset,
    lap_controller_if.slave bus
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SPLIT = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [15:0]    lap_reg_r;
    logic [3:0]     lap_cnt_r;
    logic           ovf_r;
    logic           clr_r;
    logic [HW-1:0]  hold_cnt_r;
    logic           at_max_s;
    logic           capture_s;
    logic           clr_event_s;
    logic           set_ovf_s;
    logic           clear_stop_s;

    assign at_max_s = (bus.time_in == MAX_TIME);

    // Next-state and event decode; start_stop always outranks lap_reset.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        clr_event_s  = 1'b0;
        set_ovf_s    = 1'b0;
        clear_stop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start_stop) begin
                    state_next_s = RUN;
                end else if (bus.lap_reset) begin
                    clr_event_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN, SPLIT: begin
                if (at_max_s) begin
                    state_next_s = STOP;
                    set_ovf_s    = 1'b1;
                end else if (bus.start_stop) begin
                    state_next_s = STOP;
                end else if (bus.lap_reset) begin
                    state_next_s = SPLIT;
                    capture_s    = 1'b1;
                end else if (state_r == SPLIT && bus.tick && hold_cnt_r == HOLD_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            STOP: begin
                if (bus.start_stop) begin
                    // An overflowed run cannot be resumed, only cleared.
                    if (!ovf_r) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = STOP;
                    end
                end else if (bus.lap_reset) begin
                    state_next_s = IDLE;
                    clr_event_s  = 1'b1;
                    clear_stop_s = 1'b1;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, lap capture, lap counter, overflow flag and registered clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lap_reg_r <= 16'h0000;
            lap_cnt_r <= 4'd0;
            ovf_r     <= 1'b0;
            clr_r     <= 1'b1;
        end else begin
            state_r <= state_next_s;
            clr_r   <= clr_event_s;
            if (capture_s) begin
                lap_reg_r <= bus.time_in;
            end else begin
                lap_reg_r <= lap_reg_r;
            end
            // Saturating at 9 keeps the binary increment a valid BCD digit.
            if (clear_stop_s) begin
                lap_cnt_r <= 4'd0;
            end else if (capture_s && lap_cnt_r != 4'd9) begin
                lap_cnt_r <= lap_cnt_r + 4'd1;
            end else begin
                lap_cnt_r <= lap_cnt_r;
            end
            if (clear_stop_s) begin
                ovf_r <= 1'b0;
            end else if (set_ovf_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Hold counter restarts on every capture so a same-cycle tick is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else if (capture_s || state_next_s != SPLIT) begin
            hold_cnt_r <= '0;
        end else if (bus.tick) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign bus.count   = (state_r == RUN || state_r == SPLIT) && !at_max_s;
    assign bus.frozen  = (state_r == SPLIT);
    assign bus.disp    = (state_r == SPLIT) ? lap_reg_r : bus.time_in;
    assign bus.clr     = clr_r;
    assign bus.lap_cnt = lap_cnt_r;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_lap_controller.sv
// Directed self-checking bench for lap_controller: reset, split hold,
// lap saturation, overflow halt, button priority and mid-run reset.
module tb_lap_controller;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    lap_controller_if bus ();

    lap_controller #(.HOLD_TICKS(30), .MAX_TIME(16'h9599)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        bus.start_stop = 1'b1;
        step();
        bus.start_stop = 1'b0;
    endtask

    task automatic pulse_lap(input logic [15:0] t);
        bus.time_in   = t;
        bus.lap_reset = 1'b1;
        step();
        bus.lap_reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        reset          = 1'b1;
        bus.start_stop = 1'b0;
        bus.lap_reset  = 1'b0;
        bus.tick       = 1'b0;
        bus.time_in    = 16'h0000;
        step();
        step();
        chk("rst_clr",     {15'd0, bus.clr},    16'd1);
        chk("rst_count",   {15'd0, bus.count},  16'd0);
        chk("rst_frozen",  {15'd0, bus.frozen}, 16'd0);
        chk("rst_lapcnt",  {12'd0, bus.lap_cnt}, 16'd0);
        chk("rst_ovf",     {15'd0, bus.ovf},    16'd0);

        // Release reset: clr stays high for the first cycle, then drops.
        reset = 1'b0;
        #1;
        chk("rel_clr_hi",  {15'd0, bus.clr},    16'd1);
        step();
        chk("rel_clr_lo",  {15'd0, bus.clr},    16'd0);
        chk("idle_count",  {15'd0, bus.count},  16'd0);

        pulse_ss();
        chk("run_count",   {15'd0, bus.count},  16'd1);
        chk("run_lapcnt",  {12'd0, bus.lap_cnt}, 16'd0);

        // Split at 0123 and hold through 29 ticks, release on the 30th.
        bus.time_in = 16'h0123;
        pulse_lap(16'h0123);
        chk("split_frozen", {15'd0, bus.frozen}, 16'd1);
        chk("split_lapcnt", {12'd0, bus.lap_cnt}, 16'd1);
        bus.time_in = 16'h0124;
        #1;
        chk("split_disp",   bus.disp, 16'h0123);
        chk("split_count",  {15'd0, bus.count}, 16'd1);
        ticks(29);
        chk("hold29_frozen", {15'd0, bus.frozen}, 16'd1);
        ticks(1);
        chk("hold30_frozen", {15'd0, bus.frozen}, 16'd0);
        bus.time_in = 16'h0200;
        #1;
        chk("release_disp", bus.disp, 16'h0200);

        // Both buttons together in RUN: start_stop wins.
        bus.start_stop = 1'b1;
        bus.lap_reset  = 1'b1;
        step();
        bus.start_stop = 1'b0;
        bus.lap_reset  = 1'b0;
        chk("both_lapcnt", {12'd0, bus.lap_cnt}, 16'd1);
        chk("both_frozen", {15'd0, bus.frozen}, 16'd0);
        chk("both_count",  {15'd0, bus.count},  16'd0);
        pulse_lap(16'h0200);
        chk("stop_clr",    {15'd0, bus.clr},    16'd1);
        chk("stop_lapcnt", {12'd0, bus.lap_cnt}, 16'd0);
        bus.time_in = 16'h0000;
        step();
        chk("stop_clr_lo", {15'd0, bus.clr},    16'd0);

        // Recapture in SPLIT restarts the hold counter.
        pulse_ss();
        pulse_lap(16'h0150);
        ticks(5);
        pulse_lap(16'h0210);
        chk("recap_disp",   bus.disp, 16'h0210);
        chk("recap_lapcnt", {12'd0, bus.lap_cnt}, 16'd2);
        ticks(29);
        chk("recap_hold",   {15'd0, bus.frozen}, 16'd1);
        for (int i = 0; i < 10; i++) begin
            pulse_lap(16'h0220);
        end
        pulse_lap(16'h0300);
        chk("sat_lapcnt",   {12'd0, bus.lap_cnt}, 16'd9);
        chk("sat_disp",     bus.disp, 16'h0300);

        // Reset in SPLIT with three laps recorded.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.time_in = 16'h0000;
        step();
        pulse_ss();
        pulse_lap(16'h0010);
        pulse_lap(16'h0020);
        pulse_lap(16'h0030);
        chk("pre_rst_lapcnt", {12'd0, bus.lap_cnt}, 16'd3);
        reset = 1'b1;
        bus.lap_reset = 1'b1;
        step();
        bus.lap_reset = 1'b0;
        chk("midrst_frozen", {15'd0, bus.frozen}, 16'd0);
        chk("midrst_lapcnt", {12'd0, bus.lap_cnt}, 16'd0);
        chk("midrst_clr",    {15'd0, bus.clr},    16'd1);
        chk("midrst_count",  {15'd0, bus.count},  16'd0);
        reset = 1'b0;
        step();

        // Overflow: count drops in the same cycle, STOP sticks until lap_reset.
        pulse_ss();
        pulse_lap(16'h0500);
        bus.time_in = 16'h9599;
        #1;
        chk("max_count_now", {15'd0, bus.count}, 16'd0);
        step();
        chk("ovf_set",      {15'd0, bus.ovf},    16'd1);
        chk("ovf_frozen",   {15'd0, bus.frozen}, 16'd0);
        pulse_ss();
        chk("ovf_ss_ignored", {15'd0, bus.count}, 16'd0);
        chk("ovf_ss_ovf",   {15'd0, bus.ovf},    16'd1);
        step();
        chk("ovf_still_stop", {15'd0, bus.count}, 16'd0);
        pulse_lap(16'h9599);
        chk("ovf_clr",      {15'd0, bus.clr},    16'd1);
        chk("ovf_cleared",  {15'd0, bus.ovf},    16'd0);
        chk("ovf_lapcnt",   {12'd0, bus.lap_cnt}, 16'd0);
        bus.time_in = 16'h0000;
        step();
        chk("ovf_clr_lo",   {15'd0, bus.clr},    16'd0);
        pulse_ss();
        chk("restart_count", {15'd0, bus.count}, 16'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
